// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, trap/mret, MEM wait and timeout.
// Define PERF_STALL_CNT_EN to build the 32-bit stall-cycle performance counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned WCNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_ID,
  input  logic [4:0]        rs2_ID,
  input  logic              rs1_used_ID,
  input  logic              rs2_used_ID,
  input  logic [4:0]        rd_EX,
  input  logic              mem_r_EX,
  input  logic              branch_taken_EX,
  input  logic [1:0]        exp_vector_EX,
  input  logic              mret_EX,
  input  logic              mem_req_MEM,
  input  logic              mem_ready,
  output logic              en_PC,
  output logic              en_IFID,
  output logic              flush_IFID,
  output logic              en_IDEX,
  output logic              flush_IDEX,
  output logic              flush_EXMEM,
  output logic [1:0]        pc_sel,
  output logic              trap_commit,
  output logic              bus_err,
  output logic [31:0]       stall_cycles
);

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_MTVEC = 2'd2;
  localparam logic [1:0] PC_MEPC  = 2'd3;

  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_TRAP_FLUSH = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_nxt;

  logic exc_ex;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic ex_eval;

  // Hazard detection on the ID/EX boundary; x0 never creates a dependency.
  assign exc_ex   = |exp_vector_EX;
  assign rs1_hit  = rs1_used_ID && (rs1_ID == rd_EX);
  assign rs2_hit  = rs2_used_ID && (rs2_ID == rd_EX);
  assign load_use = mem_r_EX && (rd_EX != 5'd0) && (rs1_hit || rs2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and combinational control outputs.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    en_PC        = 1'b1;
    en_IFID      = 1'b1;
    flush_IFID   = 1'b0;
    en_IDEX      = 1'b1;
    flush_IDEX   = 1'b0;
    flush_EXMEM  = 1'b0;
    pc_sel       = PC_SEQ;
    trap_commit  = 1'b0;
    bus_err      = 1'b0;
    ex_eval      = 1'b0;

    case (state)
      ST_RUN: begin
        wait_cnt_nxt = '0;
        if (mem_req_MEM && !mem_ready) begin
          en_PC        = 1'b0;
          en_IFID      = 1'b0;
          en_IDEX      = 1'b0;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WCNT_ONE;
        end else begin
          ex_eval = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
          ex_eval      = 1'b1;
        end else begin
          en_PC   = 1'b0;
          en_IFID = 1'b0;
          en_IDEX = 1'b0;
          if (wait_cnt == WCNT_LAST) begin
            state_nxt    = ST_TRAP_FLUSH;
            wait_cnt_nxt = '0;
            bus_err      = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + WCNT_ONE;
          end
        end
      end

      ST_TRAP_FLUSH: begin
        flush_IFID   = 1'b1;
        flush_IDEX   = 1'b1;
        flush_EXMEM  = 1'b1;
        pc_sel       = PC_MTVEC;
        trap_commit  = 1'b1;
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end

      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // EX-stage events only act when the pipeline is moving; trap/branch hide load-use.
    if (ex_eval) begin
      if (exc_ex) begin
        flush_IFID  = 1'b1;
        flush_IDEX  = 1'b1;
        flush_EXMEM = 1'b1;
        pc_sel      = PC_MTVEC;
        trap_commit = 1'b1;
      end else if (mret_EX) begin
        flush_IFID  = 1'b1;
        flush_IDEX  = 1'b1;
        flush_EXMEM = 1'b1;
        pc_sel      = PC_MEPC;
        trap_commit = 1'b1;
      end else if (branch_taken_EX) begin
        flush_IFID = 1'b1;
        flush_IDEX = 1'b1;
        pc_sel     = PC_BR;
      end else if (load_use) begin
        en_PC      = 1'b0;
        en_IFID    = 1'b0;
        flush_IDEX = 1'b1;
      end
    end

    if (rst) begin
      en_PC       = 1'b0;
      en_IFID     = 1'b0;
      flush_IFID  = 1'b0;
      en_IDEX     = 1'b0;
      flush_IDEX  = 1'b0;
      flush_EXMEM = 1'b0;
      pc_sel      = PC_SEQ;
      trap_commit = 1'b0;
      bus_err     = 1'b0;
    end
  end

`ifdef PERF_STALL_CNT_EN
  // Counts every cycle the PC is held; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!en_PC) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives enable and flush for the PC, IF/ID, ID/EX and EX/MEM latches, and selects the next-PC source.
- Resolves load-use hazards, taken branches, EX-stage exceptions/mret and data-memory wait states.
- Times out stuck memory accesses into a bus-error trap.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles on a MEM access before bus-error trap (>=2)
WCNT_W, 5, width of wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rs1_ID  in  5  rs1 address of instruction in ID
rs2_ID  in  5  rs2 address of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  5  destination of instruction in EX
mem_r_EX  in  1  EX instruction is a load
branch_taken_EX  in  1  EX branch/jump resolved taken
exp_vector_EX  in  2  nonzero = exception raised in EX
mret_EX  in  1  EX instruction is mret
mem_req_MEM  in  1  MEM stage has active data-memory access
mem_ready  in  1  data memory completes access this cycle
en_PC  out  1  PC register enable
en_IFID  out  1  IF/ID enable
flush_IFID  out  1  IF/ID flush
en_IDEX  out  1  ID/EX enable
flush_IDEX  out  1  ID/EX flush (bubble insert)
flush_EXMEM  out  1  EX/MEM flush
pc_sel  out  2  0=PC+4, 1=branch target, 2=mtvec, 3=mepc
trap_commit  out  1  one-cycle pulse: CSR unit records trap/mret
bus_err  out  1  one-cycle pulse: memory timeout trap cause
stall_cycles  out  32  stall performance counter (see Optional Feature)

Behaviour:
- States: RUN, MEM_WAIT, TRAP_FLUSH. Reset -> RUN, wait_cnt=0.
- While rst high: all en_*=0, all flush_*=0, pc_sel=0, trap_commit=0, bus_err=0, stall_cycles=0.
- Default outputs (no event): all en_*=1, flushes 0, pc_sel=0.
- Outputs are combinational from state + inputs. Only state, wait_cnt and stall_cycles are registered.
- RUN, evaluated in priority order:
  1. Memory wait: mem_req_MEM & !mem_ready. Freeze: all en_*=0, no flush, pc_sel=0. Next state MEM_WAIT, wait_cnt=1. Any exception/branch in EX is held, not acted on.
  2. Trap: exp_vector_EX!=0. flush_IFID=flush_IDEX=flush_EXMEM=1, pc_sel=2, trap_commit=1, en_PC=1.
  3. mret_EX (no exception): same flushes, pc_sel=3, trap_commit=1. Exception takes priority if both.
  4. Branch: branch_taken_EX. flush_IFID=1, flush_IDEX=1, pc_sel=1.
  5. Load-use: mem_r_EX & rd_EX!=0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)). en_PC=0, en_IFID=0, en_IDEX=1, flush_IDEX=1. Exactly one bubble per hazard.
  - Branch/trap suppress load-use: the ID instruction is flushed anyway.
- MEM_WAIT:
  - Freeze as above every cycle.
  - If mem_ready: unfreeze this same cycle (default outputs; EX events evaluated as in RUN items 2-5), next RUN, wait_cnt=0.
  - Else if wait_cnt==MEM_TIMEOUT-1: next TRAP_FLUSH, bus_err=1 this cycle.
  - Else wait_cnt++.
- TRAP_FLUSH, one cycle: all three flushes=1, pc_sel=2, trap_commit=1, en_*=1. Next RUN, wait_cnt=0.
- mem_ready with no mem_req_MEM is ignored.
- Async reset mid-MEM_WAIT or mid-TRAP_FLUSH returns to RUN immediately. No pending trap is retained.

Optional Feature:
PERF_STALL_CNT_EN:
- Defined: stall_cycles increments (wrapping at 2^32) every cycle in which en_PC=0 and rst low; reset clears it.
- Undefined: stall_cycles tied to 0, no counter flops.

Test Plan:
1. rd_EX=5, mem_r_EX=1, rs1_ID=5, rs1_used_ID=1 -> exactly one cycle en_PC=0, en_IFID=0, flush_IDEX=1. With rd_EX=0 -> no stall.
2. branch_taken_EX=1 and load-use true in same cycle -> pc_sel=1, flush_IFID=1, flush_IDEX=1, en_PC=1.
3. exp_vector_EX=2'b01 with mret_EX=1 -> pc_sel=2, trap_commit one pulse, all three flushes 1.
4. mem_req_MEM=1, mem_ready low 3 cycles then high -> en_* low 3 cycles, high on 4th; stall_cycles=3 (if PERF_STALL_CNT_EN).
5. mem_req_MEM=1, mem_ready never high, MEM_TIMEOUT=16 -> bus_err pulse in the 16th freeze cycle, next cycle trap_commit=1, pc_sel=2, then RUN.
6. rst asserted asynchronously during MEM_WAIT -> outputs all 0 immediately; after release state RUN, stall_cycles=0.
